// File: rtl/miniscope_rdctrl_pkg.sv
// Shared widths, FSM encoding and header format for the miniscope read/write address controller.
package miniscope_rdctrl_pkg;

    localparam int unsigned RAM_ADRB  = 11;
    localparam int unsigned RAM_WIDTH = 8;
    localparam int unsigned MXTBINS   = 5;
    localparam int unsigned DATA_W    = 2 * RAM_WIDTH;
    localparam int unsigned RD_LAT    = 2;

    localparam logic [2:0] HDR_MARK = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READ  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } rd_state_e;

    typedef struct packed {
        logic [2:0] mark;
        logic [4:0] tbins;
        logic [7:0] adr;
    } mini_hdr_t;

    // Header word announcing a readout: marker, tbin count, low byte of start address
    function automatic mini_hdr_t make_hdr(input logic [4:0] tbins, input logic [7:0] adr);
        mini_hdr_t h;
        h.mark  = HDR_MARK;
        h.tbins = tbins;
        h.adr   = adr;
        return h;
    endfunction

endpackage

// File: rtl/miniscope_rdctrl_if.sv
// Dual-port RAM connection of the miniscope controller: write port, read address, read data and parity.
interface miniscope_rdctrl_if;
    import miniscope_rdctrl_pkg::*;

    logic                fifo_wen;
    logic [RAM_ADRB-1:0] fifo_wadr_mini;
    logic [DATA_W-1:0]   fifo_wdata_mini;
    logic [RAM_ADRB-1:0] fifo_radr_mini;
    logic [DATA_W-1:0]   fifo_rdata_mini;
    logic [1:0]          parity_err_mini;

    modport master (
        output fifo_wen, fifo_wadr_mini, fifo_wdata_mini, fifo_radr_mini,
        input  fifo_rdata_mini, parity_err_mini
    );

    modport slave (
        input  fifo_wen, fifo_wadr_mini, fifo_wdata_mini, fifo_radr_mini,
        output fifo_rdata_mini, parity_err_mini
    );

endinterface

// File: rtl/miniscope_rdctrl_wrptr.sv
// Write side of the miniscope circular buffer: registered data/enable and wrapping write pointer.
module miniscope_rdctrl_wrptr
    import miniscope_rdctrl_pkg::*;
(
    input  logic                clock,
    input  logic                global_reset,
    input  logic                mini_rec_en,
    input  logic [DATA_W-1:0]   mini_data,
    output logic                fifo_wen,
    output logic [RAM_ADRB-1:0] fifo_wadr_mini,
    output logic [DATA_W-1:0]   fifo_wdata_mini
);

    // Pointer advances the cycle after a write; wraps by natural modulo
    always_ff @(posedge clock) begin
        if (global_reset) begin
            fifo_wen        <= 1'b0;
            fifo_wdata_mini <= '0;
            fifo_wadr_mini  <= '0;
        end else begin
            fifo_wen        <= mini_rec_en;
            fifo_wdata_mini <= mini_data;
            if (fifo_wen) begin
                fifo_wadr_mini <= fifo_wadr_mini + RAM_ADRB'(1);
            end
        end
    end

endmodule

// File: rtl/miniscope_rdctrl.sv
// Miniscope RAM write/read address controller with look-back readout to the DMB stream.
// Optional MINI_HEADER_EN: emit one header word ahead of the tbin data.
module miniscope_rdctrl
    import miniscope_rdctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 global_reset,
    input  logic                 mini_rec_en,
    input  logic [DATA_W-1:0]    mini_data,
    input  logic                 rd_start,
    input  logic [RAM_ADRB-1:0]  rd_offset,
    input  logic [MXTBINS-1:0]   rd_tbins,
    miniscope_rdctrl_if.master   ram,
    output logic [DATA_W-1:0]    mini_dout,
    output logic                 mini_dout_vld,
    output logic                 mini_rd_busy,
    output logic                 mini_rd_done,
    output logic [1:0]           mini_perr
);

    logic                wen;
    logic [RAM_ADRB-1:0] wadr;
    logic [DATA_W-1:0]   wdata;

    rd_state_e           state, state_nxt;
    logic [RAM_ADRB-1:0] lat_offset;
    logic [MXTBINS-1:0]  lat_tbins;
    logic [MXTBINS-1:0]  tbin_cnt;
    logic [RAM_ADRB-1:0] radr;
    logic [1:0]          flush_cnt;
    logic                rd_vld1;
`ifdef MINI_HEADER_EN
    logic                hdr_pend;
`endif

    miniscope_rdctrl_wrptr u_wrptr (
        .clock           (clock),
        .global_reset    (global_reset),
        .mini_rec_en     (mini_rec_en),
        .mini_data       (mini_data),
        .fifo_wen        (wen),
        .fifo_wadr_mini  (wadr),
        .fifo_wdata_mini (wdata)
    );

    assign ram.fifo_wen        = wen;
    assign ram.fifo_wadr_mini  = wadr;
    assign ram.fifo_wdata_mini = wdata;
    assign ram.fifo_radr_mini  = radr;

    always_ff @(posedge clock) begin
        if (global_reset) state <= IDLE;
        else              state <= state_nxt;
    end

    // Readout sequencing; tbins=0 skips READ (and still passes FLUSH when a header is sent)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (rd_start) state_nxt = LOAD;
            LOAD: begin
                if (lat_tbins == '0) begin
`ifdef MINI_HEADER_EN
                    state_nxt = FLUSH;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = READ;
                end
            end
            READ:  if (tbin_cnt == MXTBINS'(1)) state_nxt = FLUSH;
            FLUSH: if (flush_cnt == 2'(RD_LAT - 1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (global_reset) begin
            lat_offset    <= '0;
            lat_tbins     <= '0;
            tbin_cnt      <= '0;
            radr          <= '0;
            flush_cnt     <= '0;
            rd_vld1       <= 1'b0;
            mini_dout     <= '0;
            mini_dout_vld <= 1'b0;
            mini_rd_busy  <= 1'b0;
            mini_rd_done  <= 1'b0;
            mini_perr     <= '0;
`ifdef MINI_HEADER_EN
            hdr_pend      <= 1'b0;
`endif
        end else begin
            if (state == IDLE && rd_start) begin
                lat_offset <= rd_offset;
                lat_tbins  <= rd_tbins;
            end

            // Start address is a look-back from the live write pointer
            if (state == LOAD) begin
                radr     <= wadr - lat_offset;
                tbin_cnt <= lat_tbins;
            end else if (state == READ) begin
                radr     <= radr + RAM_ADRB'(1);
                tbin_cnt <= tbin_cnt - MXTBINS'(1);
            end

            flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
            rd_vld1   <= (state == READ);

`ifdef MINI_HEADER_EN
            hdr_pend <= (state == LOAD);
`endif

            if (rd_vld1) begin
                mini_dout     <= ram.fifo_rdata_mini;
                mini_dout_vld <= 1'b1;
`ifdef MINI_HEADER_EN
            end else if (hdr_pend) begin
                mini_dout     <= DATA_W'(make_hdr(5'(lat_tbins), 8'(radr)));
                mini_dout_vld <= 1'b1;
`endif
            end else begin
                mini_dout     <= '0;
                mini_dout_vld <= 1'b0;
            end

            // Parity only counts on cycles carrying a read tbin
            if (state == IDLE && rd_start) begin
                mini_perr <= '0;
            end else if (rd_vld1) begin
                mini_perr <= mini_perr | ram.parity_err_mini;
            end

            mini_rd_busy <= (state_nxt != IDLE);
            mini_rd_done <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_miniscope_rdctrl.sv
// Directed self-checking bench for miniscope_rdctrl with a READ_FIRST RAM model.
module tb_miniscope_rdctrl;
    import miniscope_rdctrl_pkg::*;

`ifdef MINI_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic                clock;
    logic                global_reset;
    logic                mini_rec_en;
    logic [DATA_W-1:0]   mini_data;
    logic                rd_start;
    logic [RAM_ADRB-1:0] rd_offset;
    logic [MXTBINS-1:0]  rd_tbins;
    logic [DATA_W-1:0]   mini_dout;
    logic                mini_dout_vld;
    logic                mini_rd_busy;
    logic                mini_rd_done;
    logic [1:0]          mini_perr;

    miniscope_rdctrl_if ram_if ();

    miniscope_rdctrl dut (
        .clock         (clock),
        .global_reset  (global_reset),
        .mini_rec_en   (mini_rec_en),
        .mini_data     (mini_data),
        .rd_start      (rd_start),
        .rd_offset     (rd_offset),
        .rd_tbins      (rd_tbins),
        .ram           (ram_if),
        .mini_dout     (mini_dout),
        .mini_dout_vld (mini_dout_vld),
        .mini_rd_busy  (mini_rd_busy),
        .mini_rd_done  (mini_rd_done),
        .mini_perr     (mini_perr)
    );

    logic [DATA_W-1:0] mem [2048];

    always @(posedge clock) begin
        ram_if.fifo_rdata_mini <= mem[ram_if.fifo_radr_mini];
        if (ram_if.fifo_wen) mem[ram_if.fifo_wadr_mini] <= ram_if.fifo_wdata_mini;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int n_writes = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Latest value written at address a, or 0 if never written
    function automatic logic [15:0] exp_val(input int a);
        int w;
        if (n_writes == 0 || a > n_writes - 1) return 16'h0000;
        w = a + 2048 * ((n_writes - 1 - a) / 2048);
        return 16'(w);
    endfunction

    task automatic write_bx(input int n);
        for (int i = 0; i < n; i++) begin
            mini_rec_en = 1'b1;
            mini_data   = 16'(n_writes);
            tick();
            n_writes++;
        end
        mini_rec_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_read(input int o, input int t, input int perr_c, input int restart_c);
        int start, first_v, ndone, done_c, nbusy, radr_first, radr_last, nzero, ne;
        logic [15:0] words[$];
        logic [15:0] ev;
        start = (((n_writes - o) % 2048) + 2048) % 2048;
        first_v = -1; ndone = 0; done_c = -1; nbusy = 0;
        radr_first = -1; radr_last = -1; nzero = 0;
        rd_offset = 11'(o);
        rd_tbins  = 5'(t);
        rd_start  = 1'b1;
        tick();
        rd_start  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0) check_eq("perr_clear", 32'(mini_perr), 32'd0);
            if (mini_rd_busy) nbusy++;
            if (mini_dout_vld) begin
                words.push_back(mini_dout);
                if (first_v < 0) first_v = c;
            end else if (mini_dout != '0) begin
                nzero++;
            end
            if (mini_rd_done) begin
                ndone++;
                done_c = c;
            end
            if (c == 1) radr_first = int'(ram_if.fifo_radr_mini);
            if (c == t) radr_last  = int'(ram_if.fifo_radr_mini);
            ram_if.parity_err_mini = (c == perr_c) ? 2'b10 : ((c == 1) ? 2'b01 : 2'b00);
            if (c == restart_c) begin
                rd_start = 1'b1;
                rd_tbins = 5'd3;
            end else begin
                rd_start = 1'b0;
            end
            tick();
        end
        ram_if.parity_err_mini = 2'b00;
        rd_start = 1'b0;

        ne = t + HDR;
        check_eq("vld_count", 32'(words.size()), 32'(ne));
        for (int i = 0; i < words.size() && i < ne; i++) begin
            if (HDR == 1 && i == 0)
                ev = 16'(make_hdr(5'(t), 8'(start)));
            else
                ev = exp_val((start + i - HDR) % 2048);
            check_eq("rd_word", 32'(words[i]), 32'(ev));
        end
        if (ne > 0) check_eq("first_vld_cycle", 32'(first_v), 32'(3 - HDR));
        check_eq("done_count", 32'(ndone), 32'd1);
        check_eq("done_cycle", 32'(done_c), (t == 0 && HDR == 0) ? 32'd1 : 32'(t + 3));
        check_eq("busy_cycles", 32'(nbusy), (t == 0 && HDR == 0) ? 32'd2 : 32'(t + 4));
        check_eq("dout_zero_idle", 32'(nzero), 32'd0);
        if (t > 0) begin
            check_eq("radr_first", 32'(radr_first), 32'(start));
            check_eq("radr_last", 32'(radr_last), 32'((start + t - 1) % 2048));
        end
    endtask

    initial begin
        int nd, nv;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        global_reset = 1'b1;
        mini_rec_en  = 1'b0;
        mini_data    = '0;
        rd_start     = 1'b0;
        rd_offset    = '0;
        rd_tbins     = '0;
        ram_if.parity_err_mini = 2'b00;
        tick(); tick(); tick();
        global_reset = 1'b0;
        tick();

        check_eq("rst_wen", 32'(ram_if.fifo_wen), 32'd0);
        check_eq("rst_wadr", 32'(ram_if.fifo_wadr_mini), 32'd0);
        check_eq("rst_radr", 32'(ram_if.fifo_radr_mini), 32'd0);
        check_eq("rst_outs", 32'({mini_dout, mini_dout_vld, mini_rd_busy, mini_rd_done, mini_perr}), 32'd0);

        // 100 bx of bx-index data, then look back 10 for 5 tbins -> 90..94
        write_bx(100);
        check_eq("wadr_100", 32'(ram_if.fifo_wadr_mini), 32'd100);
        do_read(10, 5, -1, -1);
        check_eq("perr_none", 32'(mini_perr), 32'd0);

        // Wrap to pointer 3, offset 6, 8 tbins -> 2045..4
        write_bx(1951);
        check_eq("wadr_wrap", 32'(ram_if.fifo_wadr_mini), 32'd3);
        do_read(6, 8, -1, -1);

        do_read(4, 0, -1, -1);
        do_read(0, 2, -1, -1);

        // Parity on third data tbin, sticky until next request
        do_read(20, 5, 4, -1);
        check_eq("perr_sticky", 32'(mini_perr), 32'd2);
        for (int i = 0; i < 5; i++) tick();
        check_eq("perr_hold", 32'(mini_perr), 32'd2);

        // rd_start during READ ignored
        do_read(10, 6, -1, 2);

        // Reset mid-READ
        rd_offset = 11'd10;
        rd_tbins  = 5'd10;
        rd_start  = 1'b1;
        tick();
        rd_start  = 1'b0;
        tick(); tick(); tick();
        check_eq("pre_rst_busy", 32'(mini_rd_busy), 32'd1);
        global_reset = 1'b1;
        tick();
        global_reset = 1'b0;
        n_writes = 0;
        check_eq("rst_mid_vld", 32'(mini_dout_vld), 32'd0);
        check_eq("rst_mid_busy", 32'(mini_rd_busy), 32'd0);
        check_eq("rst_mid_radr", 32'(ram_if.fifo_radr_mini), 32'd0);
        check_eq("rst_mid_wadr", 32'(ram_if.fifo_wadr_mini), 32'd0);
        check_eq("rst_mid_done", 32'(mini_rd_done), 32'd0);
        nd = 0; nv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mini_rd_done) nd++;
            if (mini_dout_vld) nv++;
        end
        check_eq("rst_no_done", 32'(nd), 32'd0);
        check_eq("rst_no_vld", 32'(nv), 32'd0);

        // Recording paused for 20 clocks
        write_bx(5);
        for (int i = 0; i < 20; i++) tick();
        check_eq("pause_wen", 32'(ram_if.fifo_wen), 32'd0);
        check_eq("pause_wadr", 32'(ram_if.fifo_wadr_mini), 32'd5);
        mini_rec_en = 1'b1;
        mini_data   = 16'h1234;
        tick();
        mini_rec_en = 1'b0;
        check_eq("resume_wen", 32'(ram_if.fifo_wen), 32'd1);
        check_eq("resume_wdata", 32'(ram_if.fifo_wdata_mini), 32'h1234);
        check_eq("resume_wadr_hold", 32'(ram_if.fifo_wadr_mini), 32'd5);
        tick();
        check_eq("resume_wadr_inc", 32'(ram_if.fifo_wadr_mini), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
